// File: rtl/rx_frame.sv
// rx_frame: SPI receive stage. Deserialises opcode, operand A and operand B
// into one instruction word and offers it to the ALU on a valid/ready handshake.
module rx_frame (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_w,
    input  logic [7:0] mosi,
    input  logic       alu_ready,
    input  logic       clr_status,
    output logic [7:0] opcode,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       instr_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       bad_op,
    output logic       overrun,
    output logic [2:0] status
);
    // Handshake: while instr_valid=1, opcode/op_a/op_b stay stable. A cycle with
    // alu_ready=1 is the transfer; instr_valid clears after it unless a completing
    // frame reloads the word in that same cycle. alu_ready is ignored when idle.

    typedef enum logic [1:0] {
        CNT_IDLE   = 2'd0,
        CNT_OPCODE = 2'd1,
        CNT_OPA    = 2'd2
    } cnt_t;

    cnt_t       byte_cnt;
    cnt_t       byte_cnt_next;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       rise;
    logic       take;
    logic       abort;
    logic       complete;
    logic       bad_next;
    logic       ovr_next;
    logic       load;
    logic [7:0] sh_opcode;
    logic [7:0] sh_op_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= spi_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // spi_w and mosi are held stable by the host around the rise, so they are
    // sampled without synchronisers.
    assign rise     = s2 & ~s3;
    assign take     = rise & spi_w;
    assign abort    = ~spi_w & (byte_cnt != CNT_IDLE);
    assign complete = take & (byte_cnt == CNT_OPA);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= CNT_IDLE;
        end else begin
            byte_cnt <= byte_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        byte_cnt_next = byte_cnt;
        if (abort) begin
            byte_cnt_next = CNT_IDLE;
        end else if (take) begin
            case (byte_cnt)
                CNT_IDLE:   byte_cnt_next = CNT_OPCODE;
                CNT_OPCODE: byte_cnt_next = CNT_OPA;
                CNT_OPA:    byte_cnt_next = CNT_IDLE;
                default:    byte_cnt_next = CNT_IDLE;
            endcase
        end
    end

    // Frame disposition: illegal opcode beats overrun beats load.
    always_comb begin
        bad_next = complete & (sh_opcode > 8'h0F);
        ovr_next = complete & ~bad_next & instr_valid & ~alu_ready;
        load     = complete & ~bad_next & ~ovr_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_opcode <= 8'h00;
            sh_op_a   <= 8'h00;
        end else begin
            if (take && byte_cnt == CNT_IDLE) begin
                sh_opcode <= mosi;
            end
            if (take && byte_cnt == CNT_OPCODE) begin
                sh_op_a <= mosi;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode      <= 8'h00;
            op_a        <= 8'h00;
            op_b        <= 8'h00;
            instr_valid <= 1'b0;
            rx_busy     <= 1'b0;
            frame_err   <= 1'b0;
            bad_op      <= 1'b0;
            overrun     <= 1'b0;
            status      <= 3'b000;
        end else begin
            if (load) begin
                opcode      <= sh_opcode;
                op_a        <= sh_op_a;
                op_b        <= mosi;
                instr_valid <= 1'b1;
            end else if (alu_ready) begin
                instr_valid <= 1'b0;
            end
            rx_busy   <= (byte_cnt_next != CNT_IDLE);
            frame_err <= abort;
            bad_op    <= bad_next;
            overrun   <= ovr_next;
            // A pulse in the clearing cycle still sets its bit.
            status    <= (clr_status ? 3'b000 : status) | {ovr_next, bad_next, abort};
        end
    end

endmodule

// File: tb/tb_rx_frame.sv
// Testbench for rx_frame: directed scenarios plus randomized frames checked
// against a frame-level reference model and an accepted-instruction scoreboard.
module tb_rx_frame;
    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic       spi_w;
    logic [7:0] mosi;
    logic       alu_ready;
    logic       clr_status;
    logic [7:0] opcode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       instr_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       bad_op;
    logic       overrun;
    logic [2:0] status;

    rx_frame dut (
        .clk         (clk),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .spi_w       (spi_w),
        .mosi        (mosi),
        .alu_ready   (alu_ready),
        .clr_status  (clr_status),
        .opcode      (opcode),
        .op_a        (op_a),
        .op_b        (op_b),
        .instr_valid (instr_valid),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .bad_op      (bad_op),
        .overrun     (overrun),
        .status      (status)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    logic [7:0]  frame_q[$];
    logic        m_valid = 1'b0;
    logic [23:0] m_instr = 24'h0;
    logic [2:0]  m_status = 3'b000;
    bit          ready_hold = 1'b0;
    int          n_ferr = 0, n_bad = 0, n_ovr = 0;
    int          e_ferr = 0, e_bad = 0, e_ovr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: pulse-cycle counts and every instruction actually transferred.
    always @(posedge clk) begin
        if (frame_err) n_ferr++;
        if (bad_op) n_bad++;
        if (overrun) n_ovr++;
        if (instr_valid && alu_ready) got_q.push_back({opcode, op_a, op_b});
    end

    task automatic flush_accepts();
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("accept", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, 32'(instr_valid), 32'(m_valid));
        check({tag, "_instr"}, 32'({opcode, op_a, op_b}), 32'(m_instr));
        check({tag, "_status"}, 32'(status), 32'(m_status));
        check({tag, "_busy"}, 32'(rx_busy), 32'(frame_q.size() != 0));
    endtask

    // Frame-level model: applied once the third byte of a frame has been taken.
    task automatic model_complete(input bit rdy, input bit clr);
        logic [7:0] op, a, b;
        logic [2:0] pulses;
        op = frame_q[0];
        a  = frame_q[1];
        b  = frame_q[2];
        frame_q.delete();
        if (clr) m_status = 3'b000;
        pulses = 3'b000;
        if (op > 8'h0F) begin
            pulses = 3'b010;
            if (m_valid && rdy) begin
                exp_q.push_back(m_instr);
                m_valid = 1'b0;
            end
        end else if (m_valid && !rdy) begin
            pulses = 3'b100;
        end else begin
            if (m_valid) exp_q.push_back(m_instr);
            m_valid = 1'b1;
            m_instr = {op, a, b};
        end
        m_status = m_status | pulses;
        e_bad += int'(pulses[1]);
        e_ovr += int'(pulses[2]);
        check("frame_pulses", 32'({overrun, bad_op, frame_err}), 32'(pulses));
        check_state("frame");
        if (m_valid && ready_hold) begin
            exp_q.push_back(m_instr);
            m_valid = 1'b0;
        end
    endtask

    // Driver: one spi_clk high/low period carrying byte b. Optional strobes put
    // alu_ready and/or clr_status high in exactly the capture cycle.
    task automatic send_byte(input logic [7:0] b, input bit strobe_rdy, input bit strobe_clr);
        @(negedge clk);
        mosi    = b;
        spi_clk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        if (strobe_rdy || strobe_clr) begin
            @(negedge clk);
            alu_ready  = alu_ready | strobe_rdy;
            clr_status = strobe_clr;
        end
        @(posedge clk);
        #1;
        if (spi_w) begin
            frame_q.push_back(b);
            if (frame_q.size() == 3) begin
                model_complete(alu_ready, strobe_clr);
            end else begin
                if (strobe_clr) m_status = 3'b000;
                check("byte_pulses", 32'({overrun, bad_op, frame_err}), 32'd0);
                check_state("byte");
            end
        end else begin
            check("ignored_pulses", 32'({overrun, bad_op, frame_err}), 32'd0);
            check_state("ignored");
        end
        if (strobe_rdy || strobe_clr) begin
            @(negedge clk);
            alu_ready  = ready_hold;
            clr_status = 1'b0;
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        spi_clk = 1'b0;
        mosi    = 8'($urandom);
        repeat ($urandom_range(3, 6)) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input bit strobe_rdy, input bit strobe_clr);
        send_byte(op, 1'b0, 1'b0);
        send_byte(a, 1'b0, 1'b0);
        send_byte(b, strobe_rdy, strobe_clr);
        flush_accepts();
    endtask

    task automatic set_ready(input bit v);
        @(negedge clk);
        alu_ready  = v;
        ready_hold = v;
        if (v && m_valid) begin
            exp_q.push_back(m_instr);
            m_valid = 1'b0;
            @(posedge clk);
            #1;
            check("ready_drop", 32'(instr_valid), 32'd0);
        end
    endtask

    task automatic clear_status();
        @(negedge clk);
        clr_status = 1'b1;
        @(posedge clk);
        #1;
        m_status = 3'b000;
        check("clr_status", 32'(status), 32'(m_status));
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    // Drop spi_w with spi_clk low; a frame in progress must abort with one pulse.
    task automatic drop_w(input bit with_rise);
        bit in_frame;
        @(posedge clk);
        @(negedge clk);
        in_frame = (frame_q.size() != 0);
        spi_w = 1'b0;
        @(posedge clk);
        #1;
        frame_q.delete();
        if (in_frame) begin
            m_status = m_status | 3'b001;
            e_ferr++;
        end
        check("abort_pulses", 32'({overrun, bad_op, frame_err}), 32'({2'b00, in_frame}));
        check_state("abort");
        if (with_rise) send_byte(8'($urandom), 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        spi_w = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        frame_q.delete();
        m_valid  = 1'b0;
        m_instr  = 24'h0;
        m_status = 3'b000;
        check("reset_pulses", 32'({overrun, bad_op, frame_err}), 32'd0);
        check_state("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int         nb;
        bit         sr;
        rst        = 1'b1;
        spi_clk    = 1'b0;
        spi_w      = 1'b1;
        mosi       = 8'h00;
        alu_ready  = 1'b0;
        clr_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset0");
        check("reset0_pulses", 32'({overrun, bad_op, frame_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Basic frame with a ready ALU: one-cycle valid.
        set_ready(1'b1);
        send_frame(8'h05, 8'h12, 8'h34, 1'b0, 1'b0);

        // Overrun: held instruction survives a second frame.
        set_ready(1'b0);
        send_frame(8'h01, 8'hAA, 8'h55, 1'b0, 1'b0);
        send_frame(8'h02, 8'h11, 8'h22, 1'b0, 1'b0);
        set_ready(1'b1);
        set_ready(1'b0);
        clear_status();

        // Accept and reload in the completion cycle: no overrun.
        send_frame(8'h03, 8'h33, 8'h44, 1'b0, 1'b0);
        send_frame(8'h04, 8'h55, 8'h66, 1'b1, 1'b0);
        set_ready(1'b1);
        set_ready(1'b0);

        // Opcode boundaries.
        send_frame(8'h20, 8'h00, 8'h00, 1'b0, 1'b0);
        clear_status();
        send_frame(8'h10, 8'h01, 8'h02, 1'b0, 1'b1);
        send_frame(8'h0F, 8'hFE, 8'hDC, 1'b0, 1'b0);
        set_ready(1'b1);
        clear_status();

        // Abort after two bytes, then a clean frame.
        send_byte(8'h07, 1'b0, 1'b0);
        send_byte(8'h08, 1'b0, 1'b0);
        drop_w(1'b1);
        send_frame(8'h03, 8'h04, 8'h05, 1'b0, 1'b0);

        // Reset mid-frame with a held instruction.
        set_ready(1'b0);
        send_frame(8'h09, 8'h0A, 8'h0B, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        send_byte(8'h07, 1'b0, 1'b0);
        reset_mid();
        send_frame(8'h0C, 8'h0D, 8'h0E, 1'b0, 1'b0);
        set_ready(1'b1);

        // Randomized frames.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) set_ready(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) begin
                nb = $urandom_range(1, 2);
                for (int k = 0; k < nb; k++) send_byte(8'($urandom), 1'b0, 1'b0);
                drop_w(1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 5) == 0) drop_w(1'b1);
            op = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            sr = !ready_hold && ($urandom_range(0, 3) == 0);
            send_frame(op, 8'($urandom), 8'($urandom), sr, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 6) == 0) clear_status();
        end

        set_ready(1'b1);
        repeat (5) @(posedge clk);
        #1;
        flush_accepts();
        check("accept_left_got", 32'(got_q.size()), 32'd0);
        check("accept_left_exp", 32'(exp_q.size()), 32'd0);
        check("frame_err_cycles", 32'(n_ferr), 32'(e_ferr));
        check("bad_op_cycles", 32'(n_bad), 32'(e_bad));
        check("overrun_cycles", 32'(n_ovr), 32'(e_ovr));

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
